// File: rtl/nx_im_drain_pkg.sv
// Shared types and defaults for the interface-monitor drain block.
package nx_im_drain_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PUSH,
    S_RELEASE
  } drain_state_t;

  // Same bit layout as the monitor's available/consumed flags.
  typedef struct packed {
    logic bank_hi;
    logic bank_lo;
  } im_bank_t;

  localparam logic [3:0] OP_READ_DEF   = 4'h1;
  localparam logic [2:0] STAT_BUSY_DEF = 3'd0;
  localparam logic [2:0] STAT_OK_DEF   = 3'd1;

  // One-hot release pattern for the selected bank.
  function automatic im_bank_t bank_onehot(input logic bank);
    im_bank_t b;
    b.bank_hi = bank;
    b.bank_lo = ~bank;
    return b;
  endfunction

endpackage

// File: rtl/nx_interface_drain.sv
// Drains the monitor capture RAM bank by bank through the indirect-access
// command/status port and streams entries on a valid/ready interface.
module nx_interface_drain
  import nx_im_drain_pkg::*;
#(
  parameter int unsigned N_DATA_BITS    = 32,
  parameter int unsigned N_ENTRIES      = 16,
  parameter int unsigned EOB_BIT        = 0,
  parameter logic [3:0]  OP_READ        = OP_READ_DEF,
  parameter logic [2:0]  STAT_BUSY      = STAT_BUSY_DEF,
  parameter logic [2:0]  STAT_OK        = STAT_OK_DEF,
  parameter int unsigned N_TIMEOUT_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [1:0]                    im_available,
  output logic [1:0]                    im_consumed,
  output logic [3:0]                    cmnd_op,
  output logic [$clog2(N_ENTRIES)-1:0]  cmnd_addr,
  output logic                          cmnd_stb,
  input  logic [2:0]                    stat_code,
  input  logic [N_DATA_BITS-1:0]        rd_dat,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [N_DATA_BITS-1:0]        out_dat,
  output logic                          out_last,
  output logic                          out_bank,
  output logic                          err,
  output logic [15:0]                   banks_drained
);

  localparam int unsigned N_ADDR_BITS = $clog2(N_ENTRIES);
  localparam int unsigned N_BANK      = N_ENTRIES / 2;
  localparam int unsigned N_CNT_BITS  = (N_BANK > 1) ? $clog2(N_BANK) : 1;

  localparam logic [N_ADDR_BITS-1:0]    BANK_HI_BASE = N_ADDR_BITS'(N_BANK);
  localparam logic [N_CNT_BITS-1:0]     CNT_LAST     = N_CNT_BITS'(N_BANK - 1);
  // Timer value whose increment reaches all-ones.
  localparam logic [N_TIMEOUT_BITS-1:0] TMR_LAST     = ~N_TIMEOUT_BITS'(1);

  drain_state_t               r_state;
  logic                       r_exp_bank;
  logic [N_ADDR_BITS-1:0]     r_addr;
  logic [N_CNT_BITS-1:0]      r_cnt;
  logic [N_TIMEOUT_BITS-1:0]  r_timer;
  logic                       r_blank;
  im_bank_t                   r_consumed;
  logic [3:0]                 r_cmnd_op;
  logic [N_ADDR_BITS-1:0]     r_cmnd_addr;
  logic                       r_cmnd_stb;
  logic                       r_out_vld;
  logic [N_DATA_BITS-1:0]     r_out_dat;
  logic                       r_out_last;
  logic                       r_out_bank;
  logic                       r_err;
  logic [15:0]                r_banks_drained;

  im_bank_t w_avail;
  logic     w_avail_exp;

  assign w_avail     = im_bank_t'(im_available);
  assign w_avail_exp = r_exp_bank ? w_avail.bank_hi : w_avail.bank_lo;

  assign im_consumed   = r_consumed;
  assign cmnd_op       = r_cmnd_op;
  assign cmnd_addr     = r_cmnd_addr;
  assign cmnd_stb      = r_cmnd_stb;
  assign out_vld       = r_out_vld;
  assign out_dat       = r_out_dat;
  assign out_last      = r_out_last;
  assign out_bank      = r_out_bank;
  assign err           = r_err;
  assign banks_drained = r_banks_drained;

  // Drain FSM; outputs are registered on entry to the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_exp_bank      <= 1'b0;
      r_addr          <= '0;
      r_cnt           <= '0;
      r_timer         <= '0;
      r_blank         <= 1'b0;
      r_consumed      <= '0;
      r_cmnd_op       <= '0;
      r_cmnd_addr     <= '0;
      r_cmnd_stb      <= 1'b0;
      r_out_vld       <= 1'b0;
      r_out_dat       <= '0;
      r_out_last      <= 1'b0;
      r_out_bank      <= 1'b0;
      r_err           <= 1'b0;
      r_banks_drained <= '0;
    end else if (flush) begin
      // Abort without releasing; the monitor keeps the bank flagged.
      r_state    <= S_IDLE;
      r_exp_bank <= 1'b0;
      r_out_vld  <= 1'b0;
      r_cmnd_stb <= 1'b0;
      r_consumed <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && w_avail_exp) begin
            r_addr      <= r_exp_bank ? BANK_HI_BASE : '0;
            r_cmnd_addr <= r_exp_bank ? BANK_HI_BASE : '0;
            r_cnt       <= '0;
            r_cmnd_op   <= OP_READ;
            r_cmnd_stb  <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cmnd_stb <= 1'b0;
          r_timer    <= '0;
          r_blank    <= 1'b1;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_blank) begin
            // Status still reflects the previous command this cycle.
            r_blank <= 1'b0;
          end else if (stat_code == STAT_OK) begin
            r_out_dat  <= rd_dat;
            r_out_last <= rd_dat[EOB_BIT] | (r_cnt == CNT_LAST);
            r_out_bank <= r_exp_bank;
            r_out_vld  <= 1'b1;
            r_state    <= S_PUSH;
          end else if (stat_code == STAT_BUSY) begin
            if (r_timer == TMR_LAST) begin
              r_err      <= 1'b1;
              r_consumed <= bank_onehot(r_exp_bank);
              r_state    <= S_RELEASE;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end else begin
            r_err      <= 1'b1;
            r_out_last <= 1'b1;
            r_consumed <= bank_onehot(r_exp_bank);
            r_state    <= S_RELEASE;
          end
        end
        S_PUSH: begin
          if (out_rdy) begin
            r_out_vld <= 1'b0;
            if (r_out_last) begin
              r_consumed <= bank_onehot(r_exp_bank);
              r_state    <= S_RELEASE;
            end else begin
              r_addr      <= r_addr + 1'b1;
              r_cmnd_addr <= r_addr + 1'b1;
              r_cnt       <= r_cnt + 1'b1;
              r_cmnd_stb  <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_RELEASE: begin
          r_consumed <= '0;
          r_exp_bank <= ~r_exp_bank;
          if (r_banks_drained != 16'hFFFF) begin
            r_banks_drained <= r_banks_drained + 16'd1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nx_interface_drain.sv
// Self-checking bench: behavioural monitor RAM model, beat scoreboard,
// table of bank drains plus hand-written corner sequences.
module tb_nx_interface_drain;

  localparam int unsigned N_DATA_BITS = 32;
  localparam int unsigned N_ENTRIES   = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   enable;
  logic                   flush;
  logic [1:0]             im_available;
  logic [1:0]             im_consumed;
  logic [3:0]             cmnd_op;
  logic [3:0]             cmnd_addr;
  logic                   cmnd_stb;
  logic [2:0]             stat_code;
  logic [N_DATA_BITS-1:0] rd_dat;
  logic                   out_vld;
  logic                   out_rdy;
  logic [N_DATA_BITS-1:0] out_dat;
  logic                   out_last;
  logic                   out_bank;
  logic                   err;
  logic [15:0]            banks_drained;

  nx_interface_drain #(
    .N_DATA_BITS    (N_DATA_BITS),
    .N_ENTRIES      (N_ENTRIES),
    .EOB_BIT        (0),
    .OP_READ        (4'h1),
    .STAT_BUSY      (3'd0),
    .STAT_OK        (3'd1),
    .N_TIMEOUT_BITS (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .flush         (flush),
    .im_available  (im_available),
    .im_consumed   (im_consumed),
    .cmnd_op       (cmnd_op),
    .cmnd_addr     (cmnd_addr),
    .cmnd_stb      (cmnd_stb),
    .stat_code     (stat_code),
    .rd_dat        (rd_dat),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_dat       (out_dat),
    .out_last      (out_last),
    .out_bank      (out_bank),
    .err           (err),
    .banks_drained (banks_drained)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_DATA_BITS-1:0] dat;
    logic                   last;
    logic                   bank;
  } beat_t;

  typedef struct {
    logic        bank;
    int          eob_addr;
    int          n_busy;
    int          exp_beats;
    logic [15:0] exp_drained;
  } vec_t;

  beat_t                  exp_q[$];
  logic [N_DATA_BITS-1:0] mem[N_ENTRIES];
  int total = 0;
  int bad   = 0;
  int cyc = 0, stb_cnt = 0, stb_cyc = 0, cons_cyc = 0;
  int cons_lo = 0, cons_hi = 0, xfer_cnt = 0;
  int n_busy = 2;
  logic stuck = 1'b0;
  logic [3:0] m_addr = '0;
  int m_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fills one bank of the RAM model and queues the beats a correct drain yields.
  task automatic prep_bank(input logic bank, input int eob);
    int  base;
    bit  done;
    beat_t b;
    base = bank ? N_ENTRIES / 2 : 0;
    done = 1'b0;
    for (int a = base; a < base + N_ENTRIES / 2; a++) begin
      mem[a] = 32'h5A00_0000 | (32'(a) << 8) | ((a == eob) ? 32'd1 : 32'd0);
      if (!done) begin
        b.dat  = mem[a];
        b.last = (a == eob) || (a == base + N_ENTRIES / 2 - 1);
        b.bank = bank;
        exp_q.push_back(b);
        done = b.last;
      end
    end
  endtask

  // Monitor model, scoreboard sink and event counters, all on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (im_consumed[0]) cons_lo++;
    if (im_consumed[1]) cons_hi++;
    if (im_consumed != 2'b00) cons_cyc = cyc;
    if (rst_n && out_vld && out_rdy) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got dat=%0h last=%0b bank=%0b, expected none",
                 out_dat, out_last, out_bank);
      end else begin
        e = exp_q.pop_front();
        check("beat", {30'd0, out_dat, out_last, out_bank}, {30'd0, e.dat, e.last, e.bank});
      end
    end
    if (rst_n && cmnd_stb) begin
      stb_cnt++;
      stb_cyc = cyc;
      check("cmnd_op", 64'(cmnd_op), 64'h1);
      m_addr = cmnd_addr;
      m_left = n_busy;
      if (stuck || n_busy > 0) begin
        stat_code = 3'd0;
      end else begin
        stat_code = 3'd1;
        rd_dat    = mem[cmnd_addr];
      end
    end else if (stuck) begin
      stat_code = 3'd0;
    end else if (m_left > 0) begin
      m_left--;
      stat_code = 3'd0;
    end else begin
      stat_code = 3'd1;
      rd_dat    = mem[m_addr];
    end
  end

  task automatic wait_release(input logic bank);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (im_consumed[bank]) begin
        found = 1'b1;
        break;
      end
    end
    check("release_seen", 64'(found), 64'd1);
    @(posedge clk); #1;
    check("consumed_pulse_width", 64'(im_consumed), 64'd0);
    im_available[bank] = 1'b0;
  endtask

  task automatic wait_vld();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (out_vld) begin
        found = 1'b1;
        break;
      end
    end
    check("out_vld_seen", 64'(found), 64'd1);
  endtask

  initial begin
    vec_t vecs[6];
    int   xb, sb, cl, ch;
    logic [N_DATA_BITS-1:0] held;

    vecs[0] = '{bank: 1'b0, eob_addr: -1, n_busy: 2, exp_beats: 8, exp_drained: 16'd1};
    vecs[1] = '{bank: 1'b1, eob_addr: 10, n_busy: 2, exp_beats: 3, exp_drained: 16'd2};
    vecs[2] = '{bank: 1'b0, eob_addr: 0,  n_busy: 2, exp_beats: 1, exp_drained: 16'd3};
    vecs[3] = '{bank: 1'b1, eob_addr: 15, n_busy: 3, exp_beats: 8, exp_drained: 16'd4};
    vecs[4] = '{bank: 1'b0, eob_addr: -1, n_busy: 0, exp_beats: 8, exp_drained: 16'd5};
    vecs[5] = '{bank: 1'b1, eob_addr: 12, n_busy: 1, exp_beats: 5, exp_drained: 16'd6};

    for (int a = 0; a < N_ENTRIES; a++) mem[a] = '0;
    stat_code    = 3'd0;
    rd_dat       = '0;
    rst_n        = 1'b0;
    enable       = 1'b1;
    flush        = 1'b0;
    out_rdy      = 1'b1;
    im_available = 2'b00;
    #12;
    check("rst_im_consumed", 64'(im_consumed), 64'd0);
    check("rst_cmnd", {56'd0, cmnd_stb, cmnd_op, cmnd_addr[2:0]}, 64'd0);
    check("rst_cmnd_addr", 64'(cmnd_addr), 64'd0);
    check("rst_out", {29'd0, out_vld, out_dat, out_last, out_bank}, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_banks_drained", 64'(banks_drained), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Hi bank flagged while lo is expected: must be ignored.
    im_available = 2'b10;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("wrong_bank_stb", 64'(stb_cnt), 64'd0);
    check("wrong_bank_consumed", 64'(cons_lo + cons_hi), 64'd0);
    im_available = 2'b00;

    // Table of complete bank drains.
    for (int i = 0; i < 6; i++) begin
      n_busy = vecs[i].n_busy;
      xb = xfer_cnt;
      cl = cons_lo;
      ch = cons_hi;
      prep_bank(vecs[i].bank, vecs[i].eob_addr);
      im_available[vecs[i].bank] = 1'b1;
      wait_release(vecs[i].bank);
      check("vec_beats", 64'(xfer_cnt - xb), 64'(vecs[i].exp_beats));
      check("vec_queue_empty", 64'(exp_q.size()), 64'd0);
      check("vec_banks_drained", 64'(banks_drained), 64'(vecs[i].exp_drained));
      check("vec_consumed_lo", 64'(cons_lo - cl), vecs[i].bank ? 64'd0 : 64'd1);
      check("vec_consumed_hi", 64'(cons_hi - ch), vecs[i].bank ? 64'd1 : 64'd0);
      check("vec_err", 64'(err), 64'd0);
    end

    // Backpressure on beat 2 of a lo bank.
    n_busy  = 2;
    out_rdy = 1'b0;
    prep_bank(1'b0, -1);
    im_available[0] = 1'b1;
    wait_vld();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    wait_vld();
    held = out_dat;
    sb = stb_cnt;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_vld", 64'(out_vld), 64'd1);
      check("stall_dat", 64'(out_dat), 64'(held));
      check("stall_no_stb", 64'(stb_cnt), 64'(sb));
    end
    out_rdy = 1'b1;
    wait_release(1'b0);
    check("stall_banks_drained", 64'(banks_drained), 64'd7);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Flush during beat 3 of a hi bank; the drain restarts on the lo bank.
    out_rdy = 1'b0;
    prep_bank(1'b1, -1);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    im_available[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_vld();
      out_rdy = 1'b1;
      @(posedge clk); #1;
      out_rdy = 1'b0;
    end
    wait_vld();
    ch = cons_hi;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_vld", 64'(out_vld), 64'd0);
    check("flush_consumed", 64'(im_consumed), 64'd0);
    check("flush_queue_empty", 64'(exp_q.size()), 64'd0);
    im_available = 2'b01;
    prep_bank(1'b0, -1);
    out_rdy = 1'b1;
    wait_release(1'b0);
    check("flush_no_hi_release", 64'(cons_hi - ch), 64'd0);
    check("flush_restart_empty", 64'(exp_q.size()), 64'd0);
    check("flush_banks_drained", 64'(banks_drained), 64'd8);

    // Command timeout with status stuck busy on the hi bank.
    stuck = 1'b1;
    xb = xfer_cnt;
    im_available[1] = 1'b1;
    wait_release(1'b1);
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_latency", 64'(cons_cyc - stb_cyc), 64'd17);
    check("timeout_no_beats", 64'(xfer_cnt - xb), 64'd0);
    check("timeout_banks_drained", 64'(banks_drained), 64'd9);
    stuck = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("final_idle_vld", 64'(out_vld), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nx_interface_drain.md
Name: nx_interface_drain

Overview:
- Consumer-side partner of the interface monitor capture RAM.
- Watches the monitor's im_available bank flags and drains the ready bank (lo half, then hi half, alternating) through the monitor's indirect-access command/status interface.
- Streams each entry out on a valid/ready port, then pulses im_consumed for that bank so the monitor toggles banks and returns credits.
- Sits between the monitor and a downstream trace/debug sink.

Parameters:
- N_DATA_BITS, 32, entry width.
- N_ENTRIES, 16, monitor RAM depth; must be even; bank size is N_ENTRIES/2.
- EOB_BIT, 0, bit index in an entry marking end-of-block; bank drain stops after that entry.
- OP_READ, 4'h1, cmnd_op value for an indirect read.
- STAT_BUSY, 3'd0, stat_code value while a command is in progress.
- STAT_OK, 3'd1, stat_code value for successful completion.
- N_TIMEOUT_BITS, 8, width of the command-completion timeout counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  drain enable; when low, no new bank is started
- flush  in  1  synchronous abort; returns to IDLE and resets bank pointer to lo
- im_available  in  2  {bank_hi, bank_lo} ready flags from the monitor
- im_consumed  out  2  {bank_hi, bank_lo} one-cycle release pulse
- cmnd_op  out  4  indirect command opcode
- cmnd_addr  out  LOG2(N_ENTRIES)  indirect command address
- cmnd_stb  out  1  one-cycle command-register write strobe
- stat_code  in  3  indirect status code
- rd_dat  in  N_DATA_BITS  indirect read data, valid when stat_code==STAT_OK
- out_vld  out  1  entry valid
- out_rdy  in  1  sink ready
- out_dat  out  N_DATA_BITS  entry data
- out_last  out  1  last entry of the bank
- out_bank  out  1  0 = lo bank, 1 = hi bank
- err  out  1  sticky: timeout or non-OK/non-BUSY status seen
- banks_drained  out  16  saturating count of released banks

Behaviour:
- Reset values: im_consumed=0, cmnd_stb=0, cmnd_op=0, cmnd_addr=0, out_vld=0, out_dat=0, out_last=0, out_bank=0, err=0, banks_drained=0. Internal state: exp_bank=0, state=IDLE.
- IDLE:
  - If enable and im_available[exp_bank], load addr = exp_bank ? N_ENTRIES/2 : 0, cnt=0, and go to ISSUE.
  - The other bank's flag is ignored; banks are strictly ordered.
- ISSUE: drive cmnd_stb=1, cmnd_op=OP_READ, cmnd_addr=addr for exactly one cycle. Clear the timer and go to WAIT.
- WAIT:
  - The first cycle after ISSUE is a blanking cycle; stat_code is ignored.
  - From then on, each cycle:
    - stat_code==STAT_BUSY: increment the timer.
    - stat_code==STAT_OK: capture rd_dat into out_dat; set out_last = (rd_dat[EOB_BIT] | cnt==N_ENTRIES/2-1); go to PUSH.
    - Any other stat_code: set err, then force out_last=1 and go to RELEASE. The partial bank is discarded.
  - When the timer reaches all-ones: set err and go to RELEASE.
- PUSH:
  - Hold out_vld=1 and stable out_dat/out_last/out_bank until out_vld&out_rdy.
  - On the transfer: if out_last, go to RELEASE; else addr++, cnt++, go to ISSUE.
- RELEASE:
  - Pulse im_consumed[exp_bank] for one cycle.
  - Toggle exp_bank and increment banks_drained (saturating at 16'hFFFF).
  - Go to IDLE. Minimum 2 cycles before the same bank flag may be re-sampled, which covers the monitor's registered im_available.
- Latency: ISSUE→first out_vld is at least 3 cycles (ISSUE, blank, OK). Throughput is one entry per 4 cycles at best.
- addr never crosses the bank boundary; the cnt limit forces out_last at entry N_ENTRIES/2-1.
- flush:
  - Takes priority in every state. Next cycle: state=IDLE, exp_bank=0, out_vld=0.
  - Does not pulse im_consumed; err and banks_drained are kept.
- enable low mid-bank: the current bank completes; only the IDLE start is gated.
- Async reset mid-operation clears all state immediately. Any in-flight indirect command completes in the monitor unobserved.

Decomposition:
- Shared package nx_im_drain_pkg:
  - state enum {IDLE, ISSUE, WAIT, PUSH, RELEASE}
  - im_bank_t struct {bank_hi, bank_lo}, matching the monitor's available/consumed layout
  - OP_READ/STAT_* defaults
- No sub-module needed. The output register stage is inline, since PUSH holds data in place.

Test Plan:
- N_ENTRIES=16, bank_lo available, 8 entries with no eob, stat OK after 2 busy cycles, out_rdy=1 → 8 beats from addr 0..7, out_last on the 8th, out_bank=0, im_consumed=2'b01 pulse, banks_drained=1.
- Next, bank_hi available with eob set in the entry at addr 10 → 3 beats from addr 8,9,10, out_last on addr 10, im_consumed=2'b10, exp_bank back to 0.
- bank_hi asserted first while exp_bank=0 → no cmnd_stb issued, im_consumed stays 0.
- Hold out_rdy=0 for 5 cycles during beat 2 → out_vld/out_dat stable, no new cmnd_stb until the transfer completes.
- stat_code stuck at STAT_BUSY with N_TIMEOUT_BITS=4 → err=1 after 15 busy cycles, im_consumed pulse for the current bank, return to IDLE.
- flush asserted in PUSH of beat 3 → out_vld=0 next cycle, no im_consumed pulse, exp_bank=0; the next bank_lo drain restarts at addr 0.
